vsq_quantizer: RTL

Per-vector scaled quantizer (VSQ encode side). It accepts a stream of signed high-precision values, one vector of VEC_LEN elements at a time, and buffers the whole vector. It derives a per-vector power-of-two scale (shift exponent) from the vector's max magnitude, then emits Q_W-bit rounded, saturated integers together with the scale factor. It produces the data/scale pairs that the VSQ dequant/accumulate path consumes.

---
 rtl/vsq_quantizer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vsq_quantizer.sv
// vsq_quantizer: buffers one vector, derives a power-of-two scale from its max magnitude, emits rounded saturated codes
module vsq_quantizer #(
    parameter int VEC_LEN = 16,
    parameter int IN_W    = 24,
    parameter int Q_W     = 4,
    parameter int SF_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       is_vsq,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_W-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Q_W-1:0]             out_data,
    output logic [SF_W-1:0]            out_scale,
    output logic [$clog2(VEC_LEN)-1:0] out_idx,
    output logic                       out_last
);
    localparam int IW = $clog2(VEC_LEN);
    localparam int QMAX = 2**(Q_W-1) - 1;
    localparam logic signed [IN_W:0] QHI = (IN_W+1)'(QMAX);
    localparam logic signed [IN_W:0] QLO = -QHI;

    generate
        if (2**SF_W <= IN_W) begin : g_sf_w_check
            $error("SF_W too narrow to hold a shift of IN_W");
        end
    endgenerate

    typedef enum logic [1:0] {COLLECT, SCALE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [IN_W-1:0]   maxabs_q, maxabs_d;
    logic [IN_W-1:0]   vbuf_q [VEC_LEN];
    logic [IN_W-1:0]   vbuf_d [VEC_LEN];
    logic              out_valid_q, out_valid_d;
    logic [Q_W-1:0]    out_data_q, out_data_d;
    logic [SF_W-1:0]   out_scale_q, out_scale_d;
    logic [IW-1:0]     out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic [IN_W-1:0]   in_abs;
    logic [SF_W-1:0]   sf_calc;
    logic [IW-1:0]     nxt_idx;

    // Round half up at IN_W+1 bits (no overflow), shift, then clamp symmetrically to +/-QMAX
    function automatic logic [Q_W-1:0] quant(input logic [IN_W-1:0] x, input logic [SF_W-1:0] s);
        logic signed [IN_W:0] half;
        logic signed [IN_W:0] r;
        half = (s == '0) ? '0 : (IN_W+1)'(1) << (s - SF_W'(1));
        r = $signed({x[IN_W-1], x}) + half;
        r = r >>> s;
        return r > QHI ? Q_W'(QMAX) : r < QLO ? Q_W'(-QMAX) : r[Q_W-1:0];
    endfunction

    assign in_abs  = in_data[IN_W-1] ? -in_data : in_data;
    assign nxt_idx = out_idx_q + IW'(1);

    // Smallest shift that brings the vector's max magnitude within QMAX; zero when scaling is bypassed
    always_comb begin
        sf_calc = '0;
        for (int s = IN_W; s >= 0; s--)
            if ((maxabs_q >> s) <= IN_W'(QMAX)) sf_calc = SF_W'(s);
        if (!is_vsq) sf_calc = '0;
    end

    // Next-state: collect into buffer, register scale and first code, then walk the buffer under backpressure
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        maxabs_d    = maxabs_q;
        vbuf_d      = vbuf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_scale_d = out_scale_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        case (state_q)
            COLLECT: if (in_valid) begin
                vbuf_d[cnt_q] = in_data;
                maxabs_d      = in_abs > maxabs_q ? in_abs : maxabs_q;
                cnt_d         = cnt_q + IW'(1);
                if (cnt_q == IW'(VEC_LEN-1)) state_d = SCALE;
            end
            SCALE: begin
                out_scale_d = sf_calc;
                out_valid_d = 1'b1;
                out_idx_d   = '0;
                out_last_d  = 1'b0;
                out_data_d  = quant(vbuf_q[0], sf_calc);
                state_d     = EMIT;
            end
            EMIT: if (out_ready) begin
                if (out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    maxabs_d    = '0;
                    state_d     = COLLECT;
                end else begin
                    out_idx_d  = nxt_idx;
                    out_data_d = quant(vbuf_q[nxt_idx], out_scale_q);
                    out_last_d = nxt_idx == IW'(VEC_LEN-1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and output registers; reset drops any partial or buffered vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            maxabs_q    <= '0;
            for (int i = 0; i < VEC_LEN; i++) vbuf_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_scale_q <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            maxabs_q    <= maxabs_d;
            vbuf_q      <= vbuf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_scale_q <= out_scale_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = state_q == COLLECT;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_scale = out_scale_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
endmodule
